// File: rtl/dsp_pkg.sv
// dsp_pkg: operand widths and OPMODE bit positions shared by the DSP slice
// B/D-path blocks, plus the pre-adder/subtractor as a single helper function.
package dsp_pkg;

  localparam int B_WIDTH = 18;
  localparam int D_WIDTH = 18;

  // Bit positions within the 2-bit OPMODE field seen by the B path.
  localparam int OPM_PREADD_SUB = 1;  // 0 = add, 1 = subtract
  localparam int OPM_PREADD_EN  = 0;  // 0 = bypass pre-adder, 1 = use it

  // Pre-adder result. Arithmetic wraps modulo 2^B_WIDTH: the carry/borrow
  // out of the top bit is discarded, and there is no saturation.
  function automatic logic [B_WIDTH-1:0] preadd(
    input logic [1:0]         opmode,
    input logic [D_WIDTH-1:0] d,
    input logic [B_WIDTH-1:0] b
  );
    logic [B_WIDTH-1:0] r;
    r = b;
    if (opmode[OPM_PREADD_EN]) begin
      if (opmode[OPM_PREADD_SUB]) r = d - b;
      else                        r = d + b;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_bypass_stage.sv
// reg_bypass_stage: one pipeline stage that is either a clock-enabled
// register with synchronous active-high reset (REG != 0) or a plain wire
// (REG == 0).
// Ports:
//   CLK  - clock, rising edge
//   RSTB - synchronous reset, active high, priority over CE
//   CE   - clock enable; register holds when low
//   d    - stage input
//   q    - stage output
module reg_bypass_stage #(
  parameter int WIDTH = 1,
  parameter int REG   = 1
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             CE,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (REG != 0) begin : g_reg
    always_ff @(posedge CLK) begin
      if (RSTB)    q <= '0;
      else if (CE) q <= d;
    end
  end else begin : g_bypass
    // Clock, reset and enable have no effect on a bypassed stage.
    logic unused_ok;
    assign unused_ok = ^{CLK, RSTB, CE};
    assign q = d;
  end

endmodule

// File: rtl/b_cascade_out.sv
// b_cascade_out: transmitting end of the DSP slice B-input cascade link.
// The selected B operand and the D operand pass through the optional B0/D
// registers and the optional pre-adder/subtractor. The result then passes
// through the optional B1 register and drives both BCOUT (next slice) and
// B_MULT (local multiplier).
// Ports:
//   CLK, RSTB        - clock and synchronous active-high reset
//   B_IN, D          - B operand and pre-adder operand
//   CEB, CED         - enables for B0/B1 (and valid bits) and for D
//   OPMODE[1:0]      - [1] add/subtract, [0] use pre-adder
//   VALID_IN         - B_IN holds a live sample this cycle
//   BCOUT, B_MULT    - stage B1 result (identical values)
//   BVALID           - BCOUT/B_MULT hold a live sample
//
// Valid semantics: VALID_IN/BVALID are valid-only qualifiers with no ready
// or backpressure. A sample advances one registered stage on every clock
// edge where CEB is high. While CEB is low every registered stage holds
// both its data and its valid bit. A VALID_IN presented while CEB is low
// is dropped.
module b_cascade_out
  import dsp_pkg::*;
#(
  parameter int B0REG = 1,
  parameter int DREG  = 1,
  parameter int B1REG = 1
) (
  input  logic               CLK,
  input  logic               RSTB,
  input  logic [B_WIDTH-1:0] B_IN,
  input  logic [D_WIDTH-1:0] D,
  input  logic               CEB,
  input  logic               CED,
  input  logic [1:0]         OPMODE,
  input  logic               VALID_IN,
  output logic [B_WIDTH-1:0] BCOUT,
  output logic [B_WIDTH-1:0] B_MULT,
  output logic               BVALID
);

  logic [B_WIDTH-1:0] b0;
  logic [D_WIDTH-1:0] d0;
  logic [B_WIDTH-1:0] p;
  logic [B_WIDTH-1:0] b1;
  logic               v0;
  logic               v1;

  reg_bypass_stage #(.WIDTH(B_WIDTH), .REG(B0REG)) u_b0 (
    .CLK(CLK), .RSTB(RSTB), .CE(CEB), .d(B_IN), .q(b0)
  );

  reg_bypass_stage #(.WIDTH(1), .REG(B0REG)) u_v0 (
    .CLK(CLK), .RSTB(RSTB), .CE(CEB), .d(VALID_IN), .q(v0)
  );

  reg_bypass_stage #(.WIDTH(D_WIDTH), .REG(DREG)) u_d (
    .CLK(CLK), .RSTB(RSTB), .CE(CED), .d(D), .q(d0)
  );

  // OPMODE is applied combinationally, so it acts on whatever b0/d0 hold
  // in the cycle before B1 captures.
  assign p = preadd(OPMODE, d0, b0);

  reg_bypass_stage #(.WIDTH(B_WIDTH), .REG(B1REG)) u_b1 (
    .CLK(CLK), .RSTB(RSTB), .CE(CEB), .d(p), .q(b1)
  );

  reg_bypass_stage #(.WIDTH(1), .REG(B1REG)) u_v1 (
    .CLK(CLK), .RSTB(RSTB), .CE(CEB), .d(v0), .q(v1)
  );

  assign BCOUT  = b1;
  assign B_MULT = b1;
  assign BVALID = v1;

endmodule
